// File: rtl/core_sequencer_if.sv
// Bus bundle between core_sequencer and the memory ports / decode datapath.
// The trap line exists only when CORE_SEQ_TRAP_EN is defined.
interface core_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_reg_write;
  logic        dec_illegal;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        reg_we;
  logic        load_capture;
  logic        retired;
`ifdef CORE_SEQ_TRAP_EN
  logic        trap;

  modport master (
    output imem_req, imem_addr, instr, pc, dmem_req, dmem_we, reg_we,
           load_capture, retired, trap,
    input  imem_ready, imem_rdata, dec_mem_read, dec_mem_write, dec_reg_write,
           dec_illegal, pc_redirect, pc_target, dmem_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr, pc, dmem_req, dmem_we, reg_we,
           load_capture, retired, trap,
    output imem_ready, imem_rdata, dec_mem_read, dec_mem_write, dec_reg_write,
           dec_illegal, pc_redirect, pc_target, dmem_ready
  );
`else
  modport master (
    output imem_req, imem_addr, instr, pc, dmem_req, dmem_we, reg_we,
           load_capture, retired,
    input  imem_ready, imem_rdata, dec_mem_read, dec_mem_write, dec_reg_write,
           dec_illegal, pc_redirect, pc_target, dmem_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr, pc, dmem_req, dmem_we, reg_we,
           load_capture, retired,
    output imem_ready, imem_rdata, dec_mem_read, dec_mem_write, dec_reg_write,
           dec_illegal, pc_redirect, pc_target, dmem_ready
  );
`endif
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK, owns pc and instr.
// Optional CORE_SEQ_TRAP_EN adds a sticky TRAP state for illegal opcodes and misaligned redirects.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
`ifdef CORE_SEQ_TRAP_EN
    S_TRAP,
`endif
    S_WRITEBACK
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_q, next_pc_q, instr_q;
  logic [31:0] pc_plus4, redirect_pc, exec_next_pc;
  logic        ill_nop, mem_op;
  logic        imem_req, dmem_req, dmem_we, reg_we, load_capture, retired;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef CORE_SEQ_TRAP_EN
  // Illegal opcodes never reach EXECUTE here, and misaligned targets trap instead.
  assign ill_nop     = 1'b0;
  assign redirect_pc = bus.pc_target;
`else
  assign ill_nop     = bus.dec_illegal;
  assign redirect_pc = bus.pc_target & ~32'h3;
`endif

  assign mem_op       = (bus.dec_mem_read | bus.dec_mem_write) & ~ill_nop;
  assign exec_next_pc = (bus.pc_redirect && !ill_nop) ? redirect_pc : pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      instr_q   <= 32'h0000_0013;
    end else begin
      state <= state_n;
      if (state == S_FETCH && bus.imem_ready) instr_q <= bus.imem_rdata;
      if (state == S_EXECUTE) next_pc_q <= exec_next_pc;
      if (state == S_WRITEBACK) pc_q <= next_pc_q;
    end
  end

  always_comb begin
    state_n      = state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_we       = 1'b0;
    load_capture = 1'b0;
    retired      = 1'b0;
    case (state)
      S_FETCH: begin
        // Held low while rst is high so the first request follows reset release.
        imem_req = ~rst;
        if (bus.imem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
`ifdef CORE_SEQ_TRAP_EN
        state_n = bus.dec_illegal ? S_TRAP : S_EXECUTE;
`else
        state_n = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        state_n = mem_op ? S_MEM : S_WRITEBACK;
`ifdef CORE_SEQ_TRAP_EN
        if (bus.pc_redirect && (bus.pc_target[1:0] != 2'b00)) state_n = S_TRAP;
`endif
      end
      S_MEM: begin
        dmem_req     = 1'b1;
        dmem_we      = bus.dec_mem_write;
        load_capture = bus.dmem_ready & bus.dec_mem_read & ~bus.dec_mem_write;
        if (bus.dmem_ready) state_n = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        reg_we  = bus.dec_reg_write & ~bus.dec_mem_write & ~ill_nop;
        retired = 1'b1;
        state_n = S_FETCH;
      end
`ifdef CORE_SEQ_TRAP_EN
      S_TRAP: state_n = S_TRAP;
`endif
      default: state_n = S_FETCH;
    endcase
  end

  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.instr        = instr_q;
  assign bus.dmem_req     = dmem_req;
  assign bus.dmem_we      = dmem_we;
  assign bus.reg_we       = reg_we;
  assign bus.load_capture = load_capture;
  assign bus.retired      = retired;
`ifdef CORE_SEQ_TRAP_EN
  assign bus.trap         = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed vector table, randomized instructions against a
// latency/pc model, reset-abort and illegal-opcode sequences.
module tb_core_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_sequencer_if bus();

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] cur_pc;

  typedef struct {
    logic [31:0] word;
    logic        mr, mw, rw, ill, redir;
    logic [31:0] tgt;
    int          iw, dw;
    int          exp_lat, exp_regwe, exp_cap, exp_dreq;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input logic [31:0] word, input logic mr, mw, rw, ill, redir,
                              input logic [31:0] tgt, input int iw, dw, lat, regwe, cap,
                              dreq, input logic [31:0] nxt);
    vec_t v;
    v.word = word; v.mr = mr; v.mw = mw; v.rw = rw; v.ill = ill; v.redir = redir;
    v.tgt = tgt; v.iw = iw; v.dw = dw; v.exp_lat = lat; v.exp_regwe = regwe;
    v.exp_cap = cap; v.exp_dreq = dreq; v.exp_next = nxt;
    return v;
  endfunction

  // Reference: latency is one cycle per stage plus one per wait; memory stage only for loads/stores.
  function automatic vec_t model(input logic [31:0] word, input logic mr, mw, rw, redir,
                                 input logic [31:0] tgt, input int iw, dw,
                                 input logic [31:0] pc);
    vec_t v;
    bit   mem;
    mem = mr | mw;
    v = mk(word, mr, mw, rw, 1'b0, redir, tgt, iw, dw, 0, 0, 0, 0, 32'h0);
    v.exp_lat   = (iw + 1) + 1 + 1 + (mem ? dw + 1 : 0) + 1;
    v.exp_regwe = (rw && !mw) ? 1 : 0;
    v.exp_cap   = (mr && !mw) ? 1 : 0;
    v.exp_dreq  = mem ? dw + 1 : 0;
    v.exp_next  = redir ? tgt : pc + 32'd4;
    return v;
  endfunction

  task automatic set_dec(input logic mr, mw, rw, ill, redir, input logic [31:0] tgt);
    bus.dec_mem_read = mr; bus.dec_mem_write = mw; bus.dec_reg_write = rw;
    bus.dec_illegal = ill; bus.pc_redirect = redir; bus.pc_target = tgt;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int fc = 0, dc = 0, cyc = 0, regwe_n = 0, cap_n = 0, dreq_n = 0;
    bit done = 0, we_bad = 0, addr_bad = 0;
    set_dec(v.mr, v.mw, v.rw, v.ill, v.redir, v.tgt);
    while (!done && cyc < 200) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      if (bus.imem_req) begin
        bus.imem_ready = (fc == v.iw);
        bus.imem_rdata = (fc == v.iw) ? v.word : $urandom;
        if (bus.imem_addr !== cur_pc) addr_bad = 1;
        fc++;
      end else begin
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
      end
      if (bus.dmem_req) begin
        bus.dmem_ready = (dc == v.dw);
        if (bus.dmem_we !== v.mw) we_bad = 1;
        dc++;
        dreq_n++;
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (cyc == 0) begin
        chk({tag, "_pc"}, bus.pc, cur_pc);
        chk({tag, "_fetch_req"}, {31'b0, bus.imem_req}, 32'd1);
      end
      if (bus.reg_we) regwe_n++;
      if (bus.load_capture) cap_n++;
      cyc++;
      if (bus.retired) begin
        done = 1;
        chk({tag, "_instr"}, bus.instr, v.word);
      end
    end
    chk({tag, "_latency"}, cyc, v.exp_lat);
    chk({tag, "_reg_we"}, regwe_n, v.exp_regwe);
    chk({tag, "_load_cap"}, cap_n, v.exp_cap);
    chk({tag, "_dmem_cycles"}, dreq_n, v.exp_dreq);
    chk({tag, "_dmem_we_bad"}, {31'b0, we_bad}, 32'd0);
    chk({tag, "_imem_addr_bad"}, {31'b0, addr_bad}, 32'd0);
    cur_pc = v.exp_next;
  endtask

  // Asserts rst for one cycle and checks reset values while rst is still high.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_pc"}, bus.pc, 32'h0);
    chk({tag, "_instr"}, bus.instr, 32'h0000_0013);
    chk({tag, "_outs"}, {26'b0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.reg_we,
                         bus.load_capture, bus.retired}, 32'd0);
`ifdef CORE_SEQ_TRAP_EN
    chk({tag, "_trap"}, {31'b0, bus.trap}, 32'd0);
`endif
    cur_pc = 32'h0;
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.dmem_ready = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    tbl[0] = mk(32'h0010_0093, 0, 0, 1, 0, 0, 32'h0,         0, 0, 4,  1, 0, 0, 32'h4);
    tbl[1] = mk(32'h0000_2103, 1, 0, 1, 0, 0, 32'h0,         2, 3, 10, 1, 1, 4, 32'h8);
    tbl[2] = mk(32'h0020_2023, 0, 1, 1, 0, 0, 32'h0,         0, 1, 6,  0, 0, 2, 32'hC);
    tbl[3] = mk(32'h0020_2023, 1, 1, 1, 0, 0, 32'h0,         1, 0, 6,  0, 0, 1, 32'h10);
    tbl[4] = mk(32'h0F00_006F, 0, 0, 1, 0, 1, 32'h100,       0, 0, 4,  1, 0, 0, 32'h100);
    tbl[5] = mk(32'hF41F_F0EF, 0, 0, 1, 0, 1, 32'h40,        0, 0, 4,  1, 0, 0, 32'h40);
    tbl[6] = mk(32'h0000_006F, 0, 0, 0, 0, 1, 32'h40,        1, 0, 5,  0, 0, 0, 32'h40);
    tbl[7] = mk(32'hFBDF_F06F, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 4,  0, 0, 0, 32'hFFFF_FFFC);
    tbl[8] = mk(32'h0000_0013, 0, 0, 1, 0, 0, 32'h0,         0, 2, 4,  1, 0, 0, 32'h0);
    tbl[9] = mk(32'h0000_0033, 0, 0, 0, 0, 0, 32'h0,         3, 0, 7,  0, 0, 0, 32'h4);

    do_reset("reset");
    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      logic mr, mw, rw, redir;
      logic [31:0] tgt;
      mr = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1)); redir = ($urandom_range(0, 3) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      run_vec($sformatf("rnd%0d", i),
              model($urandom, mr, mw, rw, redir, tgt, $urandom_range(0, 3),
                    $urandom_range(0, 3), cur_pc));
    end

    // Reset aborts a load stalled in MEM.
    begin
      bit seen = 0, wr = 0;
      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        #1;
        bus.imem_ready = bus.imem_req;
        bus.imem_rdata = 32'h0000_2103;
        bus.dmem_ready = 1'b0;
        #1;
        if (bus.reg_we) wr = 1;
        if (bus.dmem_req) seen = 1;
      end
      chk("abort_reached_mem", {31'b0, seen}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      if (bus.reg_we) wr = 1;
      @(negedge clk);
      #1;
      if (bus.reg_we) wr = 1;
      chk("abort_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
      chk("abort_imem_req_in_rst", {31'b0, bus.imem_req}, 32'd0);
      chk("abort_pc", bus.pc, 32'h0);
      chk("abort_no_reg_we", {31'b0, wr}, 32'd0);
      cur_pc = 32'h0;
    end

`ifdef CORE_SEQ_TRAP_EN
    begin
      bit tr = 0, req_seen = 0, ret_seen = 0;
      set_dec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      for (int c = 0; c < 10 && !tr; c++) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        bus.imem_ready = bus.imem_req;
        bus.imem_rdata = 32'h0000_007F;
        #1;
        if (bus.retired) ret_seen = 1;
        if (bus.trap) tr = 1;
      end
      chk("trap_ill_entered", {31'b0, tr}, 32'd1);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        #1;
        if (bus.imem_req || bus.dmem_req || bus.reg_we) req_seen = 1;
        if (bus.retired || !bus.trap) ret_seen = 1;
      end
      chk("trap_ill_quiet", {31'b0, req_seen}, 32'd0);
      chk("trap_ill_sticky_no_retire", {31'b0, ret_seen}, 32'd0);
      chk("trap_ill_pc", bus.pc, 32'h0);

      do_reset("trap_rst");
      run_vec("pre_mis", mk(32'h0000_0013, 0, 0, 1, 0, 0, 32'h0, 0, 0, 4, 1, 0, 0, 32'h4));
      tr = 0;
      set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0042);
      for (int c = 0; c < 10 && !tr; c++) begin
        @(negedge clk);
        #1;
        bus.imem_ready = bus.imem_req;
        bus.imem_rdata = 32'h0000_006F;
        #1;
        if (bus.trap) tr = 1;
      end
      chk("trap_mis_entered", {31'b0, tr}, 32'd1);
      chk("trap_mis_pc", bus.pc, 32'h4);
    end
`else
    run_vec("illegal_nop",
            mk(32'h0000_007F, 1, 1, 1, 1, 1, 32'h80, 0, 0, 4, 0, 0, 0, 32'h4));
    run_vec("mis_redirect",
            mk(32'h0000_006F, 0, 0, 1, 0, 1, 32'h0000_0043, 0, 0, 4, 1, 0, 0, 32'h40));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the RV32 datapath. It owns the program counter and the instruction register. It walks each instruction through fetch, decode, execute, memory and writeback, and gates the decoder's enables so that register-file and data-memory writes happen exactly once per instruction. It sits between the instruction/data memory ports and the decode/ALU/register-file datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request; held until accepted.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ready  in  1  fetch accepted; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction register, fed to the decoder.
- pc  out  32  address of the instruction in flight.
- dec_mem_read  in  1  decoder: instruction is a load.
- dec_mem_write  in  1  decoder: instruction is a store.
- dec_reg_write  in  1  decoder: instruction writes rd.
- dec_illegal  in  1  decoder: opcode not recognised.
- pc_redirect  in  1  datapath: taken branch or jump; sampled in EXECUTE.
- pc_target  in  32  redirect target; sampled in EXECUTE.
- dmem_req  out  1  data access request; held until accepted.
- dmem_we  out  1  qualifies dmem_req as a store.
- dmem_ready  in  1  data access complete; load data valid this cycle.
- reg_we  out  1  register-file write strobe; one-cycle pulse in WRITEBACK.
- load_capture  out  1  latch load data into the writeback register; pulses when dmem_ready is high for a load.
- retired  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky; present only with CORE_SEQ_TRAP_EN.

## Operation
States:
- FETCH: imem_req=1.
  - imem_ready=1 → instr<=imem_rdata, go to DECODE.
  - Otherwise stay.
- DECODE: one cycle for decoder/register-file read to settle.
  - dec_illegal=1 and CORE_SEQ_TRAP_EN → TRAP.
  - Otherwise → EXECUTE.
- EXECUTE: one cycle.
  - Latch next_pc = pc_redirect ? pc_target : pc+4.
  - dec_mem_read or dec_mem_write → MEM; else → WRITEBACK.
- MEM: dmem_req=1, dmem_we=dec_mem_write.
  - dmem_ready=1 → WRITEBACK; else stay.
  - If both decoder flags are set, the store wins.
- WRITEBACK:
  - reg_we = dec_reg_write & ~dec_mem_write.
  - pc <= next_pc; retired=1; → FETCH.
- TRAP: all requests and strobes low; pc frozen. Exit only via rst.

General rules:
- pc+4 is 32-bit modular: 32'hFFFF_FFFC wraps to 32'h0.
- Decoder flags are used only in DECODE through WRITEBACK; ignored in FETCH.
- Illegal instruction without the macro executes as a NOP: no memory access, reg_we=0, pc+4, retired pulses.
- instr is stable from DECODE through WRITEBACK; it changes only on a fetch handshake.

## Timing
Reset values, in the cycle after rst is sampled high:
- state=FETCH, pc=RESET_PC, next_pc=RESET_PC, instr=32'h0000_0013 (NOP).
- imem_req=0, dmem_req=0, dmem_we=0, reg_we=0, load_capture=0, retired=0, trap=0.
- imem_req rises in the first cycle with rst low.

Latency, assuming zero-wait memory (ready in the same cycle as req):
- ALU instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
- Load/store: 5 cycles.
- Each wait cycle on imem_ready or dmem_ready adds one cycle.

Handshake rules:
- A request stays asserted with constant address/we until ready is seen.
- Requests deassert in the cycle after acceptance.
- ready seen while the request is low is ignored.

Reset and redirect edge cases:
- rst during FETCH or MEM aborts the transaction; the request is low the next cycle and no register write occurs.
- rst has priority over every transition.
- Redirect to the current pc (self-loop) is legal and refetches the same address.

## Configuration
- CORE_SEQ_TRAP_EN defined:
  - TRAP state exists.
  - An illegal opcode in DECODE, or a redirect with pc_target[1:0]≠0 in EXECUTE, enters TRAP with trap=1 next cycle and no retire.
  - For a misaligned redirect, pc holds the offending instruction's address.
- CORE_SEQ_TRAP_EN undefined:
  - The trap port and TRAP state are absent.
  - Illegal opcodes retire as NOPs.
  - pc_target[1:0] is forced to 2'b00.

## Test plan
- Reset, then ADDI with zero-wait imem → imem_addr=0 on cycle 1; reg_we pulses on cycle 4; pc=4 on cycle 5; retired counts 1.
- LW with imem_ready delayed 2 cycles and dmem_ready delayed 3 cycles → dmem_req held 4 cycles with dmem_we=0; load_capture and reg_we each pulse exactly once; total latency 10 cycles.
- SW → dmem_we=1 throughout MEM; reg_we stays 0 even with dec_reg_write forced to 1.
- JAL at pc=32'h100 with pc_redirect=1 and pc_target=32'h40 → next imem_addr=32'h40. Separately, pc=32'hFFFF_FFFC without redirect → next imem_addr=32'h0.
- rst asserted mid-MEM while dmem_ready=0 → dmem_req=0 next cycle, no reg_we, pc=RESET_PC, imem_req one cycle after rst falls.
- Opcode 7'b1111111: with CORE_SEQ_TRAP_EN, trap=1, imem_req stays 0 for 20 cycles, pc unchanged. Without the macro, retired pulses and pc advances by 4.
